// File: rtl/sram_burst_controller_if.sv
// Bus-side request/write/read channels plus the SRAM macro pins
// for the burst controller.
interface sram_burst_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                  Req_Valid;
  logic                  Req_Ready;
  logic                  Req_Write;
  logic [ADDR_WIDTH-1:0] Req_Address;
  logic [LEN_WIDTH-1:0]  Req_Length;
  logic [DATA_WIDTH-1:0] Wr_Data;
  logic                  Wr_Valid;
  logic                  Wr_Ready;
  logic [DATA_WIDTH-1:0] Rd_Data;
  logic                  Rd_Valid;
  logic                  Rd_Last;
  logic                  Rd_Ready;
  logic                  Busy;
  logic                  Done;
  logic [ADDR_WIDTH-1:0] Sram_Address;
  logic [DATA_WIDTH-1:0] Sram_Write_Data;
  logic [DATA_WIDTH-1:0] Sram_Read_Data;
  logic                  Sram_Write_Enable;
  logic                  Sram_Read_Enable;

  modport master (
    output Req_Valid, Req_Write, Req_Address, Req_Length,
    output Wr_Data, Wr_Valid, Rd_Ready, Sram_Read_Data,
    input  Req_Ready, Wr_Ready, Rd_Data, Rd_Valid, Rd_Last,
    input  Busy, Done, Sram_Address, Sram_Write_Data,
    input  Sram_Write_Enable, Sram_Read_Enable
  );

  modport slave (
    input  Req_Valid, Req_Write, Req_Address, Req_Length,
    input  Wr_Data, Wr_Valid, Rd_Ready, Sram_Read_Data,
    output Req_Ready, Wr_Ready, Rd_Data, Rd_Valid, Rd_Last,
    output Busy, Done, Sram_Address, Sram_Write_Data,
    output Sram_Write_Enable, Sram_Read_Enable
  );
endinterface

// File: rtl/sram_burst_controller.sv
// Burst initiator for a negedge-sampling single-port SRAM.
// Writes stream 1 word/cycle; reads return 1 beat per 2 cycles.
module sram_burst_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  sram_burst_controller_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR       = 3'd1;
  localparam logic [2:0] WR_FLUSH = 3'd2;
  localparam logic [2:0] RD_CAPT  = 3'd3;
  localparam logic [2:0] RD_PRES  = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  len;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  done;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic                  we;
  logic                  re;
  logic                  last;

  assign last = (cnt == len);

  assign bus.Req_Ready         = (state == IDLE);
  assign bus.Wr_Ready          = (state == WR);
  assign bus.Busy              = (state != IDLE);
  assign bus.Done              = done;
  assign bus.Rd_Data           = rd_data;
  assign bus.Rd_Valid          = rd_valid;
  assign bus.Rd_Last           = rd_last;
  assign bus.Sram_Address      = sram_addr;
  assign bus.Sram_Write_Data   = sram_wdata;
  assign bus.Sram_Write_Enable = we;
  assign bus.Sram_Read_Enable  = re;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      len        <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      we         <= 1'b0;
      re         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Req_Valid) begin
            addr <= bus.Req_Address;
            len  <= bus.Req_Length;
            cnt  <= '0;
            if (bus.Req_Write) begin
              state <= WR;
            end else begin
              sram_addr <= bus.Req_Address;
              re        <= 1'b1;
              state     <= RD_CAPT;
            end
          end
        end
        WR: begin
          if (bus.Wr_Valid) begin
            sram_wdata <= bus.Wr_Data;
            sram_addr  <= addr;
            we         <= 1'b1;
            addr       <= addr + 1'b1;
            cnt        <= cnt + 1'b1;
            if (last) state <= WR_FLUSH;
          end else begin
            we <= 1'b0;
          end
        end
        // last word is committed by the SRAM during this cycle
        WR_FLUSH: begin
          we    <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        RD_CAPT: begin
          rd_data  <= bus.Sram_Read_Data;
          rd_valid <= 1'b1;
          rd_last  <= last;
          re       <= 1'b0;
          state    <= RD_PRES;
        end
        RD_PRES: begin
          if (bus.Rd_Ready) begin
            rd_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              addr      <= addr + 1'b1;
              sram_addr <= addr + 1'b1;
              cnt       <= cnt + 1'b1;
              re        <= 1'b1;
              state     <= RD_CAPT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench for sram_burst_controller with a negedge SRAM model.
// Each step drives #1 after posedge and checks DUT outputs there.
module tb_sram_burst_controller;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sram_burst_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(4)) bus ();

  sram_burst_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(4)) dut (
    .Clk_In  (clk),
    .Reset_In(rst),
    .bus     (bus)
  );

  logic [31:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.Sram_Read_Data = 32'h0;
  end

  always @(negedge clk) begin
    if (bus.Sram_Write_Enable) mem[bus.Sram_Address] <= bus.Sram_Write_Data;
    if (bus.Sram_Read_Enable) bus.Sram_Read_Data <= mem[bus.Sram_Address];
  end

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert (!(bus.Sram_Read_Enable && bus.Sram_Write_Enable)) else begin
        bad++;
        $error("FAIL re_we_excl got=%b%b exp=not both",
               bus.Sram_Read_Enable, bus.Sram_Write_Enable);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [7:0] a, input logic [3:0] l);
    bus.Req_Valid   = 1'b1;
    bus.Req_Write   = wr;
    bus.Req_Address = a;
    bus.Req_Length  = l;
    step();
    bus.Req_Valid = 1'b0;
    check("req_busy", {31'd0, bus.Busy}, 32'd1);
  endtask

  task automatic finish_done(input string tag);
    check({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
    check({tag, "_idle"}, {31'd0, bus.Req_Ready}, 32'd1);
    step();
    check({tag, "_done_pulse"}, {31'd0, bus.Done}, 32'd0);
  endtask

  task automatic wr_burst(input logic [7:0] a, input int n, input logic [31:0] base);
    int busy_cyc;
    req(1'b1, a, 4'(n - 1));
    busy_cyc = 1;
    for (int k = 0; k < n; k++) begin
      bus.Wr_Valid = 1'b1;
      bus.Wr_Data  = base + 32'(k);
      step();
      busy_cyc++;
      check("wr_we", {31'd0, bus.Sram_Write_Enable}, 32'd1);
      check("wr_addr", {24'd0, bus.Sram_Address}, {24'd0, 8'(a + 8'(k))});
    end
    bus.Wr_Valid = 1'b0;
    step();
    check("wr_we_off", {31'd0, bus.Sram_Write_Enable}, 32'd0);
    check("wr_busy_cycles", 32'(busy_cyc), 32'(n + 1));
    finish_done("wr");
  endtask

  task automatic rd_beat(input logic [7:0] a, input logic [31:0] d, input logic lst);
    check("rd_capt_addr", {24'd0, bus.Sram_Address}, {24'd0, a});
    check("rd_capt_re", {31'd0, bus.Sram_Read_Enable}, 32'd1);
    step();
    check("rd_valid", {31'd0, bus.Rd_Valid}, 32'd1);
    check("rd_data", bus.Rd_Data, d);
    check("rd_last", {31'd0, bus.Rd_Last}, {31'd0, lst});
    check("rd_re_off", {31'd0, bus.Sram_Read_Enable}, 32'd0);
    bus.Rd_Ready = 1'b1;
    step();
    bus.Rd_Ready = 1'b0;
    check("rd_valid_drop", {31'd0, bus.Rd_Valid}, 32'd0);
  endtask

  initial begin
    int beats;
    int cyc;
    logic v;
    rst             = 1'b1;
    bus.Req_Valid   = 1'b0;
    bus.Req_Write   = 1'b0;
    bus.Req_Address = 8'h0;
    bus.Req_Length  = 4'h0;
    bus.Wr_Data     = 32'h0;
    bus.Wr_Valid    = 1'b0;
    bus.Rd_Ready    = 1'b0;
    repeat (2) step();
    check("rst_req_ready", {31'd0, bus.Req_Ready}, 32'd1);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.Rd_Valid}, 32'd0);
    check("rst_enables", {30'd0, bus.Sram_Read_Enable, bus.Sram_Write_Enable}, 32'd0);
    rst = 1'b0;
    step();

    // single beat write/read
    wr_burst(8'h10, 1, 32'hDEADBEEF);
    check("mem_10", mem[8'h10], 32'hDEADBEEF);
    req(1'b0, 8'h10, 4'd0);
    rd_beat(8'h10, 32'hDEADBEEF, 1'b1);
    finish_done("rd1");

    // 4 beats across the address wrap
    wr_burst(8'hFE, 4, 32'd1);
    check("mem_fe", mem[8'hFE], 32'd1);
    check("mem_01", mem[8'h01], 32'd4);
    req(1'b0, 8'hFE, 4'd3);
    rd_beat(8'hFE, 32'd1, 1'b0);
    rd_beat(8'hFF, 32'd2, 1'b0);
    rd_beat(8'h00, 32'd3, 1'b0);
    rd_beat(8'h01, 32'd4, 1'b1);
    finish_done("rd4");

    // 16 beats with a Wr_Valid gap every 3rd cycle
    req(1'b1, 8'h80, 4'd15);
    beats = 0;
    cyc   = 0;
    while (beats < 16 && cyc < 40) begin
      v = (cyc % 3) != 2;
      bus.Wr_Valid = v;
      bus.Wr_Data  = 32'h1000 + 32'(beats);
      step();
      check("gap_we", {31'd0, bus.Sram_Write_Enable}, {31'd0, v});
      if (v) beats++;
      cyc++;
    end
    bus.Wr_Valid = 1'b0;
    check("gap_beats", 32'(beats), 32'd16);
    step();
    finish_done("gap");
    for (int k = 0; k < 16; k++)
      check("gap_mem", mem[8'h80 + 8'(k)], 32'h1000 + 32'(k));

    // read with consumer stall on beat 2
    req(1'b0, 8'h80, 4'd2);
    rd_beat(8'h80, 32'h1000, 1'b0);
    check("stall_addr", {24'd0, bus.Sram_Address}, 32'h81);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", {31'd0, bus.Rd_Valid}, 32'd1);
      check("stall_data", bus.Rd_Data, 32'h1001);
      check("stall_re", {31'd0, bus.Sram_Read_Enable}, 32'd0);
    end
    bus.Rd_Ready = 1'b1;
    step();
    bus.Rd_Ready = 1'b0;
    rd_beat(8'h82, 32'h1002, 1'b1);
    finish_done("stall");

    // reset during beat 3 of an 8-beat write
    req(1'b1, 8'h40, 4'd7);
    bus.Wr_Valid = 1'b1;
    bus.Wr_Data  = 32'hA0;
    step();
    bus.Wr_Data     = 32'hA1;
    bus.Req_Valid   = 1'b1;
    bus.Req_Write   = 1'b0;
    bus.Req_Address = 8'h00;
    check("busy_req_ready", {31'd0, bus.Req_Ready}, 32'd0);
    step();
    bus.Req_Valid = 1'b0;
    check("busy_still_wr", {31'd0, bus.Wr_Ready}, 32'd1);
    check("busy_no_re", {31'd0, bus.Sram_Read_Enable}, 32'd0);
    bus.Wr_Data = 32'hA2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.Wr_Valid = 1'b0;
    check("abort_idle", {31'd0, bus.Req_Ready}, 32'd1);
    check("abort_busy", {31'd0, bus.Busy}, 32'd0);
    check("abort_enables", {30'd0, bus.Sram_Read_Enable, bus.Sram_Write_Enable}, 32'd0);
    @(negedge clk);
    #1;
    check("abort_mem40", mem[8'h40], 32'hA0);
    check("abort_mem41", mem[8'h41], 32'hA1);
    check("abort_mem42", mem[8'h42], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
